// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } ser_state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake between the ui_in/uo_out pins and the serial subtractor.
interface serial_subtractor_if
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, zero
  );
endinterface

// File: rtl/serial_subtractor_full_sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic a_x_b;

  assign a_x_b = a ^ b;
  assign d     = a_x_b ^ bin;
  assign bout  = (~a & b) | (~a_x_b & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, WIDTH shift cycles.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ser_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             zero_q, zero_d;
  logic             busy, done, load, last;
  logic             cell_d, cell_bout;
  logic [WIDTH-1:0] d_msb;

  full_sub_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    diff_sh_d    = diff_sh_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    busy         = 1'b0;
    done         = 1'b0;
    load         = 1'b0;
    d_msb        = '0;
    d_msb[WIDTH-1] = cell_d;

    unique case (state_q)
      IDLE: begin
        load = bus.start;
      end
      SHIFT: begin
        busy      = 1'b1;
        borrow_d  = cell_bout;
        diff_sh_d = (diff_sh_q >> 1) | d_msb;
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        if (last) begin
          // Results are published only on the final shift edge.
          state_d      = DONE;
          diff_d       = diff_sh_d;
          borrow_out_d = cell_bout;
          zero_d       = (diff_sh_d == '0);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        load    = bus.start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d  = SHIFT;
      a_sh_d   = bus.a;
      b_sh_d   = bus.b;
      borrow_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      diff_sh_q    <= diff_sh_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.zero       = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a result scoreboard.
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t         sb[$];
  int unsigned  passed = 0;
  int unsigned  total = 0;
  logic [W-1:0] last_diff = '0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t     e;
    logic [W:0] full;
    full     = {1'b0, a} - {1'b0, b};
    e.diff   = full[W-1:0];
    e.borrow = full[W];
    e.zero   = (full[W-1:0] == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [W-1:0] diff,
                                    input logic borrow, input logic zero);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_diff"}, 32'(bus.diff), 32'(diff));
    check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(borrow));
    check({tag, "_zero"}, 32'(bus.zero), 32'(zero));
  endtask

  // Drive one accepted start; leaves the bench 1 time unit after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    tick();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    check("busy_on_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_result(input string tag, input int unsigned exp_lat);
    int unsigned n;
    exp_t        e;
    tick();
    n = 1;
    if (exp_lat > 1) begin
      check({tag, "_no_early_done"}, 32'(bus.done), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_diff"}, 32'(bus.diff), 32'(e.diff));
      check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e.borrow));
      check({tag, "_zero"}, 32'(bus.zero), 32'(e.zero));
      last_diff = e.diff;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    rst = 1'b0;
    check_idle_outputs("reset", '0, 1'b0, 1'b0);

    // 7 - 3, then confirm done is a single-cycle pulse and results are held.
    start_op(4'd7, 4'd3);
    wait_result("sub_7_3", W);
    tick();
    check_idle_outputs("hold_7_3", 4'd4, 1'b0, 1'b0);

    // Outputs must not move during SHIFT.
    start_op(4'd3, 4'd7);
    check("diff_hold_in_shift", 32'(bus.diff), 32'(last_diff));
    wait_result("sub_3_7", W);

    start_op(4'd5, 4'd5);
    wait_result("sub_5_5", W);
    start_op(4'd0, 4'd15);
    wait_result("sub_0_15", W);

    // start held high: back-to-back results WIDTH+1 cycles apart.
    bus.a     = 4'd9;
    bus.b     = 4'd2;
    bus.start = 1'b1;
    sb.push_back(model(4'd9, 4'd2));
    tick();
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_result("b2b0", W);
    sb.push_back(model(4'd9, 4'd2));
    wait_result("b2b1", W + 1);
    sb.push_back(model(4'd9, 4'd2));
    wait_result("b2b2", W + 1);
    bus.start = 1'b0;
    tick();
    check_idle_outputs("b2b_end", 4'd7, 1'b0, 1'b0);

    // A start pulse during SHIFT is ignored and not queued.
    start_op(4'd2, 4'd9);
    tick();
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_result("ignore_start", W - 2);
    tick();
    check("no_queued_op", 32'(bus.busy), 32'd0);

    // Reset in the 3rd SHIFT cycle abandons the operation.
    start_op(4'd10, 4'd3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check_idle_outputs("mid_reset", '0, 1'b0, 1'b0);

    // rst wins over start.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 4'd5;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_beats_start", 32'(bus.busy), 32'd0);
    tick();
    check("rst_beats_start_idle", 32'(bus.busy), 32'd0);

    start_op(4'd15, 4'd0);
    wait_result("sub_15_0", W);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
